cpu_opponent: RTL and testbench

CPU_OPPONENT -- requirements
Module: cpu_opponent

---
 rtl/battle_pkg.sv | 19 +
 rtl/lfsr16.sv | 24 ++
 rtl/cpu_opponent.sv | 172 +++++++++++++++++
 tb/tb_cpu_opponent.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/battle_pkg.sv
// Shared battle types: CPU opponent FSM states, move/species id widths and
// the HP threshold below which the optional greedy move picker engages.
package battle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GEN_TEAM,
        ST_PICK_MOVE,
        ST_ACK,
        ST_WAIT_LOW
    } cpu_state_t;

    typedef logic [4:0] move_id_t;
    typedef logic [2:0] species_id_t;

    localparam logic [7:0]  GREEDY_HP_THRESH  = 8'd32;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16/14/13/11; a zero seed would lock up the
// register, so it is replaced by the default seed.
module lfsr16
    import battle_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    logic feedback;

    assign feedback = value[15] ^ value[13] ^ value[12] ^ value[10];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            value <= (seed == 16'd0) ? LFSR_DEFAULT_SEED : seed;
        end else begin
            value <= {value[14:0], feedback};
        end
    end

endmodule

// File: rtl/cpu_opponent.sv
// CPU opponent: generates a random three-mon enemy team and picks enemy moves.
// Optional macro CPU_GREEDY_EN enables highest-power move selection at low player HP.
module cpu_opponent
    import battle_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          NUM_SPECIES = 6
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  team_req,
    input  logic                  move_req,
    input  logic [3:0][4:0]       enemy_moves,
    input  logic [3:0][7:0]       move_power,
    input  logic [7:0]            player_hp,
    output logic                  team_ack,
    output logic [2:0][2:0]       enemy_team,
    output logic                  move_ack,
    output logic [4:0]            enemy_move,
    output logic [1:0]            move_slot,
    output logic                  busy
);

    cpu_state_t       state;
    logic [15:0]      lfsr_value;
    logic [2:0][2:0]  team_work;
    logic [7:0]       used_mask;
    logic [1:0]       slot_idx;
    logic [4:0]       rej_cnt;
    logic             is_team;
    logic [1:0]       start_slot;
    logic [1:0]       scan_cnt;
    logic             found;
    logic [1:0]       best_slot;
    move_id_t         best_move;
    species_id_t      cand;
    logic             cand_ok;
    logic             pick_valid;
    species_id_t      pick_id;
    logic [1:0]       scan_slot;
    move_id_t         scan_move;
    logic             take;
    logic             greedy;

    lfsr16 u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .seed  (LFSR_SEED),
        .value (lfsr_value)
    );

    function automatic species_id_t lowest_unused(input logic [7:0] used);
        lowest_unused = '0;
        for (int i = NUM_SPECIES - 1; i >= 0; i--) begin
            if (!used[i]) lowest_unused = species_id_t'(i);
        end
    endfunction

    assign cand       = lfsr_value[2:0];
    assign cand_ok    = (int'(cand) < NUM_SPECIES) && !used_mask[cand];
    // After 16 rejections the slot is forced so team generation is bounded.
    assign pick_valid = (rej_cnt == 5'd16) || cand_ok;
    assign pick_id    = (rej_cnt == 5'd16) ? lowest_unused(used_mask) : cand;

    assign scan_slot  = greedy ? scan_cnt : start_slot + scan_cnt;
    assign scan_move  = enemy_moves[scan_slot];

`ifdef CPU_GREEDY_EN
    logic [7:0] best_pow;
    logic [7:0] scan_pow;
    logic       unused_lfsr_bits;

    assign scan_pow         = move_power[scan_slot];
    assign take             = (scan_move != 5'd0) && (!found || (greedy && scan_pow > best_pow));
    assign unused_lfsr_bits = ^lfsr_value[15:3];

    always_ff @(posedge Clk) begin
        if (state == ST_IDLE) begin
            greedy   <= (player_hp < GREEDY_HP_THRESH);
            best_pow <= 8'd0;
        end else if (state == ST_PICK_MOVE && take) begin
            best_pow <= scan_pow;
        end
    end
`else
    logic unused_inputs;

    assign take          = (scan_move != 5'd0) && !found;
    assign greedy        = 1'b0;
    assign unused_inputs = ^{player_hp, move_power, lfsr_value[15:3]};
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= ST_IDLE;
            team_ack      <= 1'b0;
            move_ack      <= 1'b0;
            busy          <= 1'b0;
            enemy_team[0] <= 3'd0;
            enemy_team[1] <= 3'd1;
            enemy_team[2] <= 3'd2;
            enemy_move    <= 5'd0;
            move_slot     <= 2'd0;
        end else begin
            team_ack <= 1'b0;
            move_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    slot_idx   <= 2'd0;
                    rej_cnt    <= 5'd0;
                    used_mask  <= 8'd0;
                    start_slot <= lfsr_value[1:0];
                    scan_cnt   <= 2'd0;
                    found      <= 1'b0;
                    best_slot  <= 2'd0;
                    best_move  <= 5'd0;
                    if (team_req) begin
                        state   <= ST_GEN_TEAM;
                        is_team <= 1'b1;
                        busy    <= 1'b1;
                    end else if (move_req) begin
                        state   <= ST_PICK_MOVE;
                        is_team <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                ST_GEN_TEAM: begin
                    if (pick_valid) begin
                        team_work[slot_idx] <= pick_id;
                        used_mask[pick_id]  <= 1'b1;
                        rej_cnt             <= 5'd0;
                        slot_idx            <= slot_idx + 2'd1;
                        if (slot_idx == 2'd2) state <= ST_ACK;
                    end else begin
                        rej_cnt <= rej_cnt + 5'd1;
                    end
                end
                ST_PICK_MOVE: begin
                    if (take) begin
                        found     <= 1'b1;
                        best_slot <= scan_slot;
                        best_move <= scan_move;
                    end
                    scan_cnt <= scan_cnt + 2'd1;
                    if (scan_cnt == 2'd3) state <= ST_ACK;
                end
                ST_ACK: begin
                    if (is_team) begin
                        enemy_team <= team_work;
                        team_ack   <= 1'b1;
                    end else begin
                        enemy_move <= best_move;
                        move_slot  <= best_slot;
                        move_ack   <= 1'b1;
                    end
                    state <= ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
                    if (!team_req && !move_req) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_opponent.sv
// Directed, table-driven bench for cpu_opponent with an independent LFSR
// model used to predict the random scan start slot.
module tb_cpu_opponent;

    logic            Clk;
    logic            Reset;
    logic            team_req;
    logic            move_req;
    logic [3:0][4:0] enemy_moves;
    logic [3:0][7:0] move_power;
    logic [7:0]      player_hp;
    logic            team_ack;
    logic [2:0][2:0] enemy_team;
    logic            move_ack;
    logic [4:0]      enemy_move;
    logic [1:0]      move_slot;
    logic            busy;

    int total = 0;
    int bad   = 0;

    localparam logic [8:0] RST_TEAM = {3'd2, 3'd1, 3'd0};

    cpu_opponent dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .team_req    (team_req),
        .move_req    (move_req),
        .enemy_moves (enemy_moves),
        .move_power  (move_power),
        .player_hp   (player_hp),
        .team_ack    (team_ack),
        .enemy_team  (enemy_team),
        .move_ack    (move_ack),
        .enemy_move  (enemy_move),
        .move_slot   (move_slot),
        .busy        (busy)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    logic [15:0] m_lfsr;
    always @(posedge Clk) begin
        if (Reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    typedef struct {
        logic [3:0][4:0] moves;
        logic [3:0][7:0] pow;
        logic [7:0]      hp;
        logic [4:0]      exp_move;
        logic [1:0]      exp_slot;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] exp_scan(input logic [3:0][4:0] mv, input logic [1:0] st);
        logic [1:0] s;
        for (int k = 0; k < 4; k++) begin
            s = st + 2'(k);
            if (mv[s] != 5'd0) return s;
        end
        return 2'd0;
    endfunction

    // Issue one move request from IDLE; called right after a negedge.
    task automatic do_move(input logic [3:0][4:0] mv, input logic [3:0][7:0] pw,
                           input logic [7:0] hp, output logic [4:0] gm,
                           output logic [1:0] gs, output logic [1:0] st, output int lat);
        bit got;
        enemy_moves = mv;
        move_power  = pw;
        player_hp   = hp;
        move_req    = 1'b1;
        st          = m_lfsr[1:0];
        got         = 1'b0;
        lat         = 0;
        @(negedge Clk);
        while (!got && lat < 20) begin
            @(negedge Clk);
            lat++;
            if (move_ack) got = 1'b1;
        end
        gm = enemy_move;
        gs = move_slot;
        move_req = 1'b0;
        if (!got) begin
            check("move_ack_timeout", 32'(lat), 32'd5);
        end
        @(negedge Clk);
        if (move_ack || busy) check("move_ack_pulse_busy", {move_ack, busy}, 2'b00);
    endtask

    task automatic do_team(input int hold);
        logic [8:0] prev;
        bit         got;
        bit         partial;
        int         lat;
        int         extra;
        prev     = enemy_team;
        got      = 1'b0;
        partial  = 1'b0;
        lat      = 0;
        extra    = 0;
        team_req = 1'b1;
        @(negedge Clk);
        while (!got && lat < 60) begin
            @(negedge Clk);
            lat++;
            if (team_ack) got = 1'b1;
            else if (enemy_team !== prev) partial = 1'b1;
        end
        check("team_ack_seen", 32'(got), 32'd1);
        check("team_latency_le52", 32'(lat <= 52), 32'd1);
        check("team_no_partial", 32'(partial), 32'd0);
        check("team_distinct", 32'((enemy_team[0] != enemy_team[1]) && (enemy_team[0] != enemy_team[2])
                                   && (enemy_team[1] != enemy_team[2])), 32'd1);
        check("team_ids_lt6", 32'((enemy_team[0] < 6) && (enemy_team[1] < 6) && (enemy_team[2] < 6)), 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge Clk);
            if (team_ack) extra++;
        end
        check("team_no_second_ack", 32'(extra), 32'd0);
        check("team_busy_held", 32'(busy), 32'd1);
        team_req = 1'b0;
        @(negedge Clk);
        check("team_busy_cleared", 32'(busy), 32'd0);
    endtask

    initial begin : main
        logic [4:0]      gm;
        logic [1:0]      gs;
        logic [1:0]      st;
        int              lat;
        logic [3:0][4:0] mv;
        logic [3:0]      seen;
        int              acks;
        int              macks;
        logic [4:0]      held_move;

        Reset       = 1'b1;
        team_req    = 1'b0;
        move_req    = 1'b0;
        enemy_moves = '0;
        move_power  = '0;
        player_hp   = 8'd200;

        vecs.push_back('{{5'd0, 5'd0, 5'd7, 5'd0}, {8'd1, 8'd2, 8'd3, 8'd4}, 8'd200, 5'd7, 2'd1});
        vecs.push_back('{{5'd0, 5'd0, 5'd0, 5'd0}, {8'd9, 8'd9, 8'd9, 8'd9}, 8'd200, 5'd0, 2'd0});
        vecs.push_back('{{5'd31, 5'd0, 5'd0, 5'd0}, {8'd5, 8'd0, 8'd0, 8'd0}, 8'd10, 5'd31, 2'd3});
        vecs.push_back('{{5'd0, 5'd0, 5'd0, 5'd5}, {8'd0, 8'd0, 8'd0, 8'd50}, 8'd200, 5'd5, 2'd0});
        vecs.push_back('{{5'd0, 5'd12, 5'd0, 5'd0}, {8'd0, 8'd70, 8'd0, 8'd0}, 8'd32, 5'd12, 2'd2});
`ifdef CPU_GREEDY_EN
        vecs.push_back('{{5'd4, 5'd3, 5'd2, 5'd1}, {8'd0, 8'd90, 8'd90, 8'd40}, 8'd20, 5'd2, 2'd1});
        vecs.push_back('{{5'd4, 5'd3, 5'd2, 5'd1}, {8'd200, 8'd90, 8'd90, 8'd40}, 8'd31, 5'd4, 2'd3});
`endif

        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        repeat (10) @(negedge Clk);
        check("rst_team", 32'(enemy_team), 32'(RST_TEAM));
        check("rst_acks", {team_ack, move_ack}, 2'b00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_move", {enemy_move, move_slot}, 7'd0);

        foreach (vecs[i]) begin
            do_move(vecs[i].moves, vecs[i].pow, vecs[i].hp, gm, gs, st, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
            check($sformatf("vec%0d_move", i), 32'(gm), 32'(vecs[i].exp_move));
            check($sformatf("vec%0d_slot", i), 32'(gs), 32'(vecs[i].exp_slot));
        end

        do_team(10);
        do_team(3);
        do_team(1);

        // Both requests together: the team request wins and the held move
        // request is not serviced until both lines drop.
        team_req = 1'b1;
        move_req = 1'b1;
        acks  = 0;
        macks = 0;
        repeat (70) begin
            @(negedge Clk);
            if (team_ack) acks++;
            if (move_ack) macks++;
        end
        team_req = 1'b0;
        repeat (4) begin
            @(negedge Clk);
            if (move_ack) macks++;
        end
        check("both_team_ack_once", 32'(acks), 32'd1);
        check("both_no_move_ack", 32'(macks), 32'd0);
        check("both_busy_while_move_held", 32'(busy), 32'd1);
        move_req = 1'b0;
        @(negedge Clk);
        check("both_busy_cleared", 32'(busy), 32'd0);

        do_move({5'd0, 5'd0, 5'd7, 5'd0}, '0, 8'd200, gm, gs, st, lat);
        held_move = gm;
        repeat (6) @(negedge Clk);
        check("move_held_between_acks", {enemy_move, move_slot}, {held_move, 2'd1});

        // Reset during the second PICK_MOVE cycle abandons the request.
        enemy_moves = {5'd0, 5'd0, 5'd9, 5'd0};
        move_req = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        Reset    = 1'b1;
        move_req = 1'b0;
        @(negedge Clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_acks", {team_ack, move_ack}, 2'b00);
        check("midrst_team", 32'(enemy_team), 32'(RST_TEAM));
        check("midrst_move", {enemy_move, move_slot}, 7'd0);
        Reset = 1'b0;
        macks = 0;
        repeat (8) begin
            @(negedge Clk);
            if (move_ack) macks++;
        end
        check("midrst_no_ack", 32'(macks), 32'd0);

        // Random scan: start slot predicted from the LFSR model.
        seen = 4'b0;
        for (int n = 0; n < 1000; n++) begin
            for (int s = 0; s < 4; s++) begin
                mv[s] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            end
            do_move(mv, {8'd10, 8'd20, 8'd30, 8'd40}, 8'd200, gm, gs, st, lat);
            if (lat != 5 || gs != exp_scan(mv, st) || gm != mv[exp_scan(mv, st)]) begin
                check($sformatf("rand%0d_lat_slot_move", n), {8'(lat), 6'(gs), 5'(gm)},
                      {8'd5, 6'(exp_scan(mv, st)), 5'(mv[exp_scan(mv, st)])});
            end else begin
                total++;
            end
            seen[gs] = 1'b1;
        end
        check("rand_slot_coverage", 32'(seen), 32'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
